// File: rtl/pwm_bank_if.sv
// pwm_bank_if: register-write bus, channel enables and PWM outputs of pwm_bank.
interface pwm_bank_if #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 5
);
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [CNT_W-1:0]  reg_wdata;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;
    modport master (output reg_wr_en, reg_addr, reg_wdata, en_out, en_pwm,
                    input  pwm_out, period_start);
    modport slave  (input  reg_wr_en, reg_addr, reg_wdata, en_out, en_pwm,
                    output pwm_out, period_start);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shadowed duty/TOP/prescaler registers that
// switch over only at a period boundary.
module pwm_bank #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 5
) (
    input logic       clk,
    input logic       rst_n,
    pwm_bank_if.slave bus
);
    localparam logic [CNT_W-1:0]  ONES    = '1;
    localparam logic [ADDR_W-1:0] A_TOP   = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] A_PRESC = ADDR_W'(NUM_CH + 1);

    logic [CNT_W-1:0]  duty_pend_q [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q  [NUM_CH];
    logic [CNT_W-1:0]  top_pend_q, top_act_q, presc_pend_q, presc_act_q;
    logic [CNT_W-1:0]  presc_cnt_q, presc_cnt_d, cnt_q, cnt_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              ps_q, tick, boundary;

    always_comb begin
        tick        = presc_cnt_q == presc_act_q;
        boundary    = tick && cnt_q == top_act_q;
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        cnt_d       = boundary ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
        pwm_d       = '0;
        // all-ones duty is forced 100 %, so the counter never has to exceed TOP
        for (int c = 0; c < NUM_CH; c++)
            pwm_d[c] = bus.en_out[c] & (~bus.en_pwm[c] | (duty_act_q[c] == ONES) | (cnt_q < duty_act_q[c]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                duty_pend_q[c] <= '0;
                duty_act_q[c]  <= '0;
            end
            top_pend_q   <= ONES;
            top_act_q    <= ONES;
            presc_pend_q <= '0;
            presc_act_q  <= '0;
            presc_cnt_q  <= '0;
            cnt_q        <= '0;
            pwm_q        <= '0;
            ps_q         <= 1'b0;
        end else begin
            // active copies take the pre-write pending values, so a write on a
            // boundary cycle waits for the following boundary
            if (boundary) begin
                for (int c = 0; c < NUM_CH; c++) duty_act_q[c] <= duty_pend_q[c];
                top_act_q   <= top_pend_q;
                presc_act_q <= presc_pend_q;
            end
            if (bus.reg_wr_en) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (bus.reg_addr == ADDR_W'(c)) duty_pend_q[c] <= bus.reg_wdata;
                if (bus.reg_addr == A_TOP)   top_pend_q   <= bus.reg_wdata;
                if (bus.reg_addr == A_PRESC) presc_pend_q <= bus.reg_wdata;
            end
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            ps_q        <= boundary;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed stimulus with a cycle model feeding an expected-output
// queue, plus window counts of duty and period length.
module tb_pwm_bank;
    localparam int NUM_CH = 16;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();
    pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [NUM_CH:0] exp_q[$];
    logic [NUM_CH:0] e;
    logic [7:0] m_dp[NUM_CH], m_da[NUM_CH];
    logic [7:0] m_tp, m_ta, m_pp, m_pa, m_pc, m_cnt;
    logic m_tick, m_bnd;
    logic [NUM_CH-1:0] m_exp;
    int hi_cnt[NUM_CH];
    int ps_cnt, hi, n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference model: expected outputs are queued at each edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin m_dp[c] = 8'h00; m_da[c] = 8'h00; end
            m_tp = 8'hFF; m_ta = 8'hFF; m_pp = 8'h00; m_pa = 8'h00; m_pc = 8'h00; m_cnt = 8'h00;
            exp_q.delete();
        end else begin
            m_tick = m_pc == m_pa;
            m_bnd  = m_tick && m_cnt == m_ta;
            for (int c = 0; c < NUM_CH; c++)
                m_exp[c] = bus.en_out[c] ? (bus.en_pwm[c] ? (m_da[c] == 8'hFF || m_cnt < m_da[c]) : 1'b1) : 1'b0;
            exp_q.push_back({m_bnd, m_exp});
            if (m_bnd) begin
                m_ta = m_tp; m_pa = m_pp;
                for (int c = 0; c < NUM_CH; c++) m_da[c] = m_dp[c];
            end
            if (bus.reg_wr_en) begin
                if (int'(bus.reg_addr) < NUM_CH) m_dp[int'(bus.reg_addr)] = bus.reg_wdata;
                else if (int'(bus.reg_addr) == NUM_CH) m_tp = bus.reg_wdata;
                else if (int'(bus.reg_addr) == NUM_CH + 1) m_pp = bus.reg_wdata;
            end
            m_cnt = m_bnd ? 8'h00 : m_tick ? 8'(m_cnt + 8'h01) : m_cnt;
            m_pc  = m_tick ? 8'h00 : 8'(m_pc + 8'h01);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pwm_out", 32'(bus.pwm_out), 32'(e[NUM_CH-1:0]));
            check("sb_period_start", 32'(bus.period_start), 32'(e[NUM_CH]));
        end
    end

    task automatic wr(input int a, input logic [7:0] d);
        bus.reg_wr_en = 1'b1;
        bus.reg_addr  = ADDR_W'(a);
        bus.reg_wdata = d;
        @(negedge clk);
        bus.reg_wr_en = 1'b0;
    endtask

    task automatic wait_ps(input int limit);
        int k = 0;
        @(negedge clk);
        while (!bus.period_start && k < limit) begin @(negedge clk); k++; end
        check("ps_wait", 32'(bus.period_start), 32'd1);
    endtask

    task automatic window(input int len);
        ps_cnt = 0;
        for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(bus.pwm_out[c]);
            ps_cnt += int'(bus.period_start);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.reg_wr_en = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        bus.en_out = '1; bus.en_pwm = '1;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", 32'(bus.pwm_out), 32'd0);
        check("rst_period_start", 32'(bus.period_start), 32'd0);
        rst_n = 1'b1;
        // default period: 256 clk, 64 high
        wr(0, 8'h40);
        wr(2, 8'h80);
        wait_ps(300);
        window(256);
        check("t1_ch0_high", 32'(hi_cnt[0]), 32'd64);
        check("t1_ps_in_period", 32'(ps_cnt), 32'd1);
        check("t1_ps_spacing", 32'(bus.period_start), 32'd1);
        // shadowing: rewrite DUTY[2] mid-period at cnt 0x20
        n = 0;
        while (m_cnt != 8'h20 && n < 300) begin @(negedge clk); n++; end
        check("t3_reach_cnt20", 32'(m_cnt), 32'h20);
        wr(2, 8'h10);
        hi = 0; n = 0;
        while (!bus.period_start && n < 300) begin hi += int'(bus.pwm_out[2]); @(negedge clk); n++; end
        check("t3_old_duty_rest", 32'(hi), 32'd96);
        window(256);
        check("t3_new_duty", 32'(hi_cnt[2]), 32'd16);
        // TOP=9, PRESC=3 and extreme duties
        wr(NUM_CH, 8'd9);
        wr(NUM_CH + 1, 8'd3);
        wr(1, 8'd5);
        wr(3, 8'hFF);
        wr(4, 8'h00);
        wr(5, 8'h0C);
        wait_ps(300);
        wait_ps(300);
        window(40);
        check("t2_ch1_high", 32'(hi_cnt[1]), 32'd20);
        check("t2_ps_in_period", 32'(ps_cnt), 32'd1);
        check("t2_ps_spacing", 32'(bus.period_start), 32'd1);
        check("t4_duty_ff", 32'(hi_cnt[3]), 32'd40);
        check("t4_duty_00", 32'(hi_cnt[4]), 32'd0);
        check("t4_duty_gt_top", 32'(hi_cnt[5]), 32'd40);
        // gating, one-cycle latency
        bus.en_pwm[6] = 1'b0;
        #1 check("t5_static_before_edge", 32'(bus.pwm_out[6]), 32'd0);
        @(negedge clk);
        check("t5_static_high", 32'(bus.pwm_out[6]), 32'd1);
        bus.en_out[6] = 1'b0;
        #1 check("t5_off_before_edge", 32'(bus.pwm_out[6]), 32'd1);
        @(negedge clk);
        check("t5_forced_low", 32'(bus.pwm_out[6]), 32'd0);
        bus.en_out[6] = 1'b1;
        @(negedge clk);
        check("t5_reenabled", 32'(bus.pwm_out[6]), 32'd1);
        bus.en_pwm[6] = 1'b1;
        // unmapped address, then asynchronous reset mid-period
        wr(NUM_CH + 2, 8'h01);
        repeat (100) @(negedge clk);
        check("t6_pre_reset_ch3", 32'(bus.pwm_out[3]), 32'd1);
        #3 rst_n = 1'b0;
        #1 check("t6_async_pwm_out", 32'(bus.pwm_out), 32'd0);
        check("t6_async_ps", 32'(bus.period_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.pwm_out != '0) hi++;
        end while (!bus.period_start && n < 400);
        check("t6_first_period_len", 32'(n), 32'd256);
        check("t6_outputs_low", 32'(hi), 32'd0);
        window(256);
        check("t6_duty0_reset", 32'(hi_cnt[0]), 32'd0);
        check("t6_duty3_reset", 32'(hi_cnt[3]), 32'd0);
        check("t6_ps_reset_period", 32'(ps_cnt), 32'd1);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
